// File: rtl/sysid_check_pkg.sv
// rtl/sysid_check_pkg.sv - shared types and constants for the sysid boot checker
package sysid_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic SYSID_WADDR_ID = 1'b0;
    localparam logic SYSID_WADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_check_wdog.sv
// rtl/sysid_check_wdog.sv - per-read stall counter for the sysid boot checker
module sysid_check_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // Count stalled cycles of the current read; cleared when a new read begins
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Expiry fires during the stalled cycle whose ending edge is the last allowed one
    assign expired = en && (count == LAST);

endmodule

// File: rtl/sysid_boot_checker.sv
// rtl/sysid_boot_checker.sv - reads sysid ID/timestamp after reset and reports pass/fail/timeout
module sysid_boot_checker
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1516721602,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic        sys_ok,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t      state_q, state_d;
    logic        auto_q, auto_d;
    logic        addr_d, read_d, busy_d, done_d, id_ok_d, ts_ok_d, timeout_d, sys_ok_d;
    logic [31:0] id_value_d, ts_value_d;
    logic        launch, abort, wd_clr, wd_en, wd_expired;

    assign wd_en = avm_read && avm_waitrequest;

    sysid_check_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

    // Next-state and next-output logic for the check sequence
    always_comb begin
        state_d    = state_q;
        auto_d     = auto_q;
        addr_d     = avm_address;
        read_d     = avm_read;
        busy_d     = busy;
        done_d     = done;
        id_ok_d    = id_ok;
        ts_ok_d    = ts_ok;
        timeout_d  = timeout;
        id_value_d = id_value;
        ts_value_d = ts_value;
        launch     = 1'b0;
        abort      = 1'b0;
        wd_clr     = 1'b0;

        case (state_q)
            IDLE:  launch = auto_q || start;
            DONE:  launch = start;
            RD_ID: begin
                if (!avm_waitrequest) begin
                    id_value_d = avm_readdata;
                    addr_d     = SYSID_WADDR_TS;
                    wd_clr     = 1'b1;
                    state_d    = RD_TS;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    ts_value_d = avm_readdata;
                    read_d     = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    id_ok_d    = (id_value == EXPECTED_ID);
                    ts_ok_d    = (avm_readdata == EXPECTED_TS) || !CHECK_TS;
                    state_d    = DONE;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d    = RD_ID;
            auto_d     = 1'b0;
            read_d     = 1'b1;
            addr_d     = SYSID_WADDR_ID;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            id_ok_d    = 1'b0;
            ts_ok_d    = 1'b0;
            timeout_d  = 1'b0;
            id_value_d = '0;
            ts_value_d = '0;
            wd_clr     = 1'b1;
        end

        // Captured words are kept on timeout so the failing read is visible
        if (abort) begin
            read_d    = 1'b0;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
            done_d    = 1'b1;
            id_ok_d   = 1'b0;
            ts_ok_d   = 1'b0;
            state_d   = DONE;
        end

        sys_ok_d = done_d && id_ok_d && ts_ok_d && !timeout_d;
    end

    // State and registered outputs; reset re-arms the automatic check
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            auto_q      <= 1'b1;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            sys_ok      <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            state_q     <= state_d;
            auto_q      <= auto_d;
            avm_address <= addr_d;
            avm_read    <= read_d;
            busy        <= busy_d;
            done        <= done_d;
            id_ok       <= id_ok_d;
            ts_ok       <= ts_ok_d;
            timeout     <= timeout_d;
            sys_ok      <= sys_ok_d;
            id_value    <= id_value_d;
            ts_value    <= ts_value_d;
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb/tb_sysid_boot_checker.sv - self-checking bench for sysid_boot_checker
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1516721602;
    localparam int          TMO    = 8;
    localparam int          STUCK  = 1000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;

    logic        a_addr, a_read, a_busy, a_done, a_id_ok, a_ts_ok, a_timeout, a_sys_ok;
    logic [31:0] a_idv, a_tsv;
    logic        b_addr, b_read, b_busy, b_done, b_id_ok, b_ts_ok, b_timeout, b_sys_ok;
    logic [31:0] b_idv, b_tsv;

    always #5 clock = ~clock;

    sysid_boot_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(a_addr), .avm_read(a_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .busy(a_busy), .done(a_done), .id_ok(a_id_ok), .ts_ok(a_ts_ok),
        .timeout(a_timeout), .sys_ok(a_sys_ok), .id_value(a_idv), .ts_value(a_tsv)
    );

    sysid_boot_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0), .TIMEOUT_CYCLES(TMO)
    ) dut_nc (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(b_addr), .avm_read(b_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .busy(b_busy), .done(b_done), .id_ok(b_id_ok), .ts_ok(b_ts_ok),
        .timeout(b_timeout), .sys_ok(b_sys_ok), .id_value(b_idv), .ts_value(b_tsv)
    );

    int          errors = 0;
    int          checks = 0;
    int          cfg_id, cfg_ts, rem_id, rem_ts, edges;
    logic [31:0] mem_id, mem_ts;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic setup(input int sid, input int sts, input logic [31:0] mid, input logic [31:0] mts);
        cfg_id = sid;
        cfg_ts = sts;
        rem_id = sid;
        rem_ts = sts;
        mem_id = mid;
        mem_ts = mts;
    endtask

    // Slave model: each read stalls for its configured number of cycles, then returns its word
    task automatic serve(input int budget, input int start_at, output int n);
        logic wr, stalled, paddr;
        n = 0;
        while (!a_done && n < budget) begin
            wr              = a_read && ((a_addr ? rem_ts : rem_id) > 0);
            avm_waitrequest = wr;
            avm_readdata    = a_addr ? mem_ts : mem_id;
            start           = (n == start_at);
            stalled         = a_read && wr;
            paddr           = a_addr;
            @(posedge clock);
            n++;
            if (stalled) begin
                if (paddr) rem_ts--;
                else rem_id--;
            end
            @(negedge clock);
            start = 1'b0;
            if (stalled && a_read) check_bit("addr_stable", a_addr, paddr);
        end
        avm_waitrequest = 1'b0;
    endtask

    task automatic reset_release();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check_bit("restart_done", a_done, 1'b0);
        check_bit("restart_read", a_read, 1'b1);
        check_bit("restart_addr", a_addr, 1'b0);
        check_word("restart_idv", a_idv, 32'd0);
        check_word("restart_tsv", a_tsv, 32'd0);
        check_bit("restart_timeout", a_timeout, 1'b0);
    endtask

    // Reference: expected outcome from the stall counts and slave words
    task automatic expect_run(input string tag, input int launch);
        bit          to_id, to_ts, to;
        int          exp_edges;
        logic [31:0] e_idv, e_tsv;
        logic        e_idok, e_tsok;
        to_id     = (cfg_id >= TMO);
        to_ts     = !to_id && (cfg_ts >= TMO);
        to        = to_id || to_ts;
        exp_edges = launch + (to_id ? TMO : (cfg_id + 1 + (to_ts ? TMO : cfg_ts + 1)));
        e_idv     = to_id ? 32'd0 : mem_id;
        e_tsv     = to ? 32'd0 : mem_ts;
        e_idok    = !to && (mem_id == EXP_ID);
        e_tsok    = !to && (mem_ts == EXP_TS);
        check_word({tag, "_edges"}, 32'(edges), 32'(exp_edges));
        check_bit({tag, "_done"}, a_done, 1'b1);
        check_bit({tag, "_read"}, a_read, 1'b0);
        check_bit({tag, "_busy"}, a_busy, 1'b0);
        check_bit({tag, "_timeout"}, a_timeout, to);
        check_word({tag, "_idv"}, a_idv, e_idv);
        check_word({tag, "_tsv"}, a_tsv, e_tsv);
        check_bit({tag, "_idok"}, a_id_ok, e_idok);
        check_bit({tag, "_tsok"}, a_ts_ok, e_tsok);
        check_bit({tag, "_sysok"}, a_sys_ok, e_idok && e_tsok);
        check_bit({tag, "_nc_tsok"}, b_ts_ok, !to);
        check_bit({tag, "_nc_sysok"}, b_sys_ok, e_idok);
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        check_bit("rst_done", a_done, 1'b0);
        check_bit("rst_read", a_read, 1'b0);
        check_bit("rst_busy", a_busy, 1'b0);
        check_bit("rst_sysok", a_sys_ok, 1'b0);
        check_word("rst_idv", a_idv, 32'd0);

        // zero-wait pass straight out of reset
        setup(0, 0, EXP_ID, EXP_TS);
        reset_release();
        serve(60, -1, edges);
        expect_run("zero_wait", 1);

        // timestamp off by one
        setup(0, 0, EXP_ID, EXP_TS + 32'd1);
        pulse_start();
        serve(60, -1, edges);
        expect_run("ts_bad", 0);

        // four stalls on each read, from reset
        setup(4, 4, EXP_ID, EXP_TS);
        reset_release();
        serve(60, -1, edges);
        expect_run("wait4", 1);

        // timestamp read stuck
        setup(2, STUCK, EXP_ID, EXP_TS);
        pulse_start();
        serve(60, -1, edges);
        expect_run("tmo_ts", 0);

        // ID read stuck
        setup(STUCK, 0, EXP_ID, EXP_TS);
        pulse_start();
        serve(60, -1, edges);
        expect_run("tmo_id", 0);

        // start pulsed while stalled in the timestamp read
        setup(0, 5, EXP_ID, EXP_TS);
        pulse_start();
        serve(60, 2, edges);
        expect_run("start_ignored", 0);

        // reset while stalled on the ID read
        setup(STUCK, 0, EXP_ID, EXP_TS);
        pulse_start();
        serve(3, -1, edges);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_bit("midrst_read", a_read, 1'b0);
        check_bit("midrst_busy", a_busy, 1'b0);
        check_bit("midrst_done", a_done, 1'b0);
        check_bit("midrst_timeout", a_timeout, 1'b0);
        setup(1, 2, EXP_ID, EXP_TS);
        reset = 1'b0;
        serve(60, -1, edges);
        expect_run("after_rst", 1);

        // randomized stalls and slave words
        for (int i = 0; i < 10; i++) begin
            setup(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                  ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom,
                  ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom);
            pulse_start();
            serve(60, -1, edges);
            expect_run("rand", 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sysid_boot_checker.md
# sysid_boot_checker

Avalon-MM master that sits directly downstream of the system-ID slave in the Nios II system. After reset, or on request, it reads the ID word (word address 0) and the timestamp word (word address 1), compares both against build-time expected values, and reports pass/fail/timeout. Its status outputs gate board bring-up logic and drive a diagnostic LED, so no software is needed to detect a mismatched SOF/ELF pairing.

## Interface
- `EXPECTED_ID`, default 0: expected 32-bit value at word address 0.
- `EXPECTED_TS`, default 1516721602: expected 32-bit timestamp at word address 1.
- `CHECK_TS`, default 1: 1 = compare timestamp; 0 = `ts_ok` is forced to 1 at completion (the read is still performed).
- `TIMEOUT_CYCLES`, default 255: maximum waitrequest-high cycles per read; range 1..65535.

- `clock`  in  1  system clock.
- `reset`  in  1  synchronous reset, active-high.
- `start`  in  1  single-cycle re-check request.
- `avm_address`  out  1  word address to the sysid slave.
- `avm_read`  out  1  read strobe.
- `avm_waitrequest`  in  1  interconnect stall.
- `avm_readdata`  in  32  read data; valid in a cycle with `avm_read`=1 and `avm_waitrequest`=0.
- `busy`  out  1  check in progress.
- `done`  out  1  result valid; level, held until next start or reset.
- `id_ok`  out  1  ID matched.
- `ts_ok`  out  1  timestamp matched, or `CHECK_TS`=0.
- `timeout`  out  1  a read exceeded `TIMEOUT_CYCLES`.
- `sys_ok`  out  1  `done & id_ok & ts_ok & ~timeout`.
- `id_value`  out  32  captured ID word.
- `ts_value`  out  32  captured timestamp word.

## Operation
- All outputs are registered. Reset value of every output is 0; FSM state is IDLE; the auto-start flag is set.
- FSM states: IDLE, RD_ID, RD_TS, DONE.
- IDLE: if the auto-start flag is set, or `start`=1 → RD_ID. Drive `avm_read`=1, `avm_address`=0, `busy`=1. Clear the auto-start flag.
- RD_ID: hold address and read stable while `avm_waitrequest`=1. On the first cycle with waitrequest=0:
  - capture `avm_readdata` → `id_value`;
  - set `avm_address`=1;
  - clear the wait counter;
  - → RD_TS.
- RD_TS: same handshake. On accept:
  - capture → `ts_value`;
  - drop `avm_read` and `busy`;
  - set `done`=1, `id_ok`=(`id_value`==`EXPECTED_ID`), `ts_ok`=(`avm_readdata`==`EXPECTED_TS`) | ~`CHECK_TS`;
  - → DONE.
- Timeout: the wait counter increments on each cycle with read and waitrequest both high. When it reaches `TIMEOUT_CYCLES`:
  - drop `avm_read`;
  - set `timeout`=1, `done`=1, `id_ok`=0, `ts_ok`=0;
  - keep captured values (an un-read word stays 0);
  - → DONE.
- DONE: `start`=1 clears `done`, `id_ok`, `ts_ok`, `timeout`, `id_value`, `ts_value`, and enters RD_ID in the same edge (identical to the IDLE transition).
- `start` in RD_ID or RD_TS is ignored; there is no queuing.
- Reset mid-read: `avm_read` is 0 from the next edge, all results are cleared, and the check restarts automatically.
- Comparison is exact 32-bit equality; no masking.

## Timing
- Edge numbering: E0 is the first edge with `reset`=0.
- Zero-wait-state path:
  - E0: `avm_read`=1, addr 0;
  - E1: `id_value` captured, addr 1;
  - E2: `ts_value` captured, `avm_read`=0, `done`=1.
  - Total: 3 clocks from reset release to `done`.
- Each waitrequest-high cycle adds one clock to the affected read.
- Timeout: `done`/`timeout` assert on the edge ending the `TIMEOUT_CYCLES`-th stalled cycle of that read.
- `start` sampled at edge Ek in DONE: `done`=0 and `avm_read`=1 after Ek; `done`=1 again after Ek+2 with no waits.
- `avm_address` never changes while `avm_read`=1 and `avm_waitrequest`=1.

## Structure
- Package `sysid_check_pkg` holds:
  - the state enum (IDLE, RD_ID, RD_TS, DONE);
  - constants `SYSID_WADDR_ID`=0 and `SYSID_WADDR_TS`=1.
- One sub-module, `sysid_check_wdog`: the per-read stall counter.
  - Inputs: `clock`, `reset`, `clr`, `en`.
  - Output: `expired`.
  - Counter width: `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- Slave returns 0 / 1516721602, waitrequest always 0:
  - `done` and `sys_ok`=1 exactly 3 clocks after reset release;
  - `id_value`=0, `ts_value`=1516721602.
- Timestamp returns 1516721603:
  - `id_ok`=1, `ts_ok`=0, `sys_ok`=0;
  - rerun with `CHECK_TS`=0 gives `ts_ok`=1.
- Waitrequest high for 4 cycles on each read:
  - address and read are stable throughout;
  - `done` at 11 clocks;
  - `sys_ok`=1.
- With `TIMEOUT_CYCLES`=8, waitrequest stuck high on read 2:
  - `timeout`=1, `done`=1, `id_ok`=0, `ts_ok`=0;
  - `avm_read`=0 after the 8th stall;
  - `id_value` retained.
- `start` pulsed during RD_TS: ignored. `start` pulsed in DONE: fresh check with results cleared on the next cycle.
- `reset` asserted while stalled in RD_ID: `avm_read`=0 next edge, all outputs 0; after release the check completes normally.
